// File: rtl/alu_accum_ctrl.sv
// alu_accum_ctrl: command sequencer and accumulator in front of the combinational ALU.
// It drives the ALU from registers, captures the ALU result one cycle later, and
// returns that result on a valid/ready port.
module alu_accum_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_cin,
    input  logic             cmd_cin_sel,
    output logic [OP_W-1:0]  alu_op,
    output logic             alu_in_c,
    output logic [WIDTH-1:0] alu_in_x,
    output logic [WIDTH-1:0] alu_in_y,
    input  logic [WIDTH-1:0] alu_out_s,
    input  logic             alu_out_c,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_s,
    output logic             res_c,
    output logic             res_zero,
    output logic             res_of,
    output logic [WIDTH-1:0] acc
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] acc_nx;
    logic [OP_W-1:0]  op_q, op_q_nx;
    logic [WIDTH-1:0] y_q, y_q_nx;
    logic             cin_q, cin_q_nx;
    logic             c_flag, c_flag_nx;
    logic [WIDTH-1:0] res_s_nx;
    logic             res_c_nx, res_zero_nx, res_of_nx, res_valid_nx;
    logic             accept;

    // Ready is a decode of the state register, forced low while reset is held.
    assign cmd_ready = (state == IDLE) & ~rst;
    assign accept    = cmd_valid & (state == IDLE);

    // The ALU sees only registered values, so its inputs are stable for the whole EXEC cycle.
    assign alu_op   = op_q;
    assign alu_in_c = cin_q;
    assign alu_in_x = acc;
    assign alu_in_y = y_q;

    // Next-state and next-register values; every target defaults to holding its value.
    always_comb begin
        state_nx     = state;
        acc_nx       = acc;
        op_q_nx      = op_q;
        y_q_nx       = y_q;
        cin_q_nx     = cin_q;
        c_flag_nx    = c_flag;
        res_s_nx     = res_s;
        res_c_nx     = res_c;
        res_zero_nx  = res_zero;
        res_of_nx    = res_of;
        res_valid_nx = res_valid;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_load) begin
                        acc_nx       = cmd_data;
                        res_s_nx     = cmd_data;
                        res_c_nx     = 1'b0;
                        res_of_nx    = 1'b0;
                        res_zero_nx  = (cmd_data == WIDTH'(0));
                        res_valid_nx = 1'b1;
                        state_nx     = RESP;
                    end else begin
                        op_q_nx  = cmd_op;
                        y_q_nx   = cmd_data;
                        cin_q_nx = cmd_cin_sel ? c_flag : cmd_cin;
                        state_nx = EXEC;
                    end
                end
            end
            EXEC: begin
                res_s_nx     = alu_out_s;
                res_c_nx     = alu_out_c;
                res_zero_nx  = alu_zero;
                res_of_nx    = alu_overflow;
                acc_nx       = alu_out_s;
                c_flag_nx    = alu_out_c;
                res_valid_nx = 1'b1;
                state_nx     = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_nx = 1'b0;
                    state_nx     = IDLE;
                end
            end
            default: begin
                res_valid_nx = 1'b0;
                state_nx     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            op_q      <= '0;
            y_q       <= '0;
            cin_q     <= 1'b0;
            c_flag    <= 1'b0;
            res_s     <= '0;
            res_c     <= 1'b0;
            res_zero  <= 1'b0;
            res_of    <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            op_q      <= op_q_nx;
            y_q       <= y_q_nx;
            cin_q     <= cin_q_nx;
            c_flag    <= c_flag_nx;
            res_s     <= res_s_nx;
            res_c     <= res_c_nx;
            res_zero  <= res_zero_nx;
            res_of    <= res_of_nx;
            res_valid <= res_valid_nx;
        end
    end

endmodule

// File: tb/tb_alu_accum_ctrl.sv
// Directed bench for alu_accum_ctrl with a behavioural stand-in for the team ALU.
module tb_alu_accum_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_load, cmd_cin, cmd_cin_sel;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [2:0] alu_op;
    logic       alu_in_c;
    logic [3:0] alu_in_x, alu_in_y, alu_out_s;
    logic       alu_out_c, alu_zero, alu_overflow;
    logic       res_valid, res_ready;
    logic [3:0] res_s;
    logic       res_c, res_zero, res_of;
    logic [3:0] acc;

    int errors = 0;
    int checks = 0;

    alu_accum_ctrl #(.WIDTH(4), .OP_W(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cin(cmd_cin), .cmd_cin_sel(cmd_cin_sel),
        .alu_op(alu_op), .alu_in_c(alu_in_c), .alu_in_x(alu_in_x), .alu_in_y(alu_in_y),
        .alu_out_s(alu_out_s), .alu_out_c(alu_out_c), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_s(res_s), .res_c(res_c), .res_zero(res_zero), .res_of(res_of),
        .acc(acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: 000 add, 001 and, 010 xor, others pass y. Returns {s, c, zero, of}.
    function automatic logic [6:0] alu_f(input logic [2:0] op, input logic c,
                                         input logic [3:0] x, input logic [3:0] y);
        logic [4:0] t;
        logic [3:0] s;
        logic       co, of;
        co = 1'b0;
        of = 1'b0;
        case (op)
            3'b000: begin
                t  = {1'b0, x} + {1'b0, y} + {4'b0000, c};
                s  = t[3:0];
                co = t[4];
                of = (x[3] == y[3]) && (s[3] != x[3]);
            end
            3'b001:  s = x & y;
            3'b010:  s = x ^ y;
            default: s = y;
        endcase
        return {s, co, (s == 4'h0), of};
    endfunction

    logic [6:0] alu_res;
    always_comb begin
        alu_res      = alu_f(alu_op, alu_in_c, alu_in_x, alu_in_y);
        alu_out_s    = alu_res[6:3];
        alu_out_c    = alu_res[2];
        alu_zero     = alu_res[1];
        alu_overflow = alu_res[0];
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Present a command and wait (bounded) for it to be accepted; returns at the negedge after accept.
    task automatic send(input logic ld, input logic [2:0] op, input logic [3:0] d,
                        input logic ci, input logic sel);
        int n;
        cmd_load = ld; cmd_op = op; cmd_data = d; cmd_cin = ci; cmd_cin_sel = sel;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL send_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1; res_ready = 1'b0;
        cmd_load = 1'b0; cmd_op = 3'b000; cmd_data = 4'h0; cmd_cin = 1'b0; cmd_cin_sel = 1'b0;
        repeat (2) step();
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", res_valid); end
        checks++;
        if ({acc, res_s, res_c, res_zero, res_of} !== 11'h000) begin
            errors++;
            $display("FAIL reset_regs: acc=%h res_s=%h c=%b z=%b of=%b want all 0",
                     acc, res_s, res_c, res_zero, res_of);
        end
        cmd_valid = 1'b0;
        rst = 1'b0;
        step();
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_load();
        send(1'b1, 3'b000, 4'h7, 1'b0, 1'b0);
        checks++;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL load_latency: res_valid=%b want 1", res_valid); end
        checks++;
        if ({res_s, res_zero, acc} !== {4'h7, 1'b0, 4'h7}) begin
            errors++;
            $display("FAIL load_result: res_s=%h zero=%b acc=%h want 7 0 7", res_s, res_zero, acc);
        end
        consume();
        checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_done: res_valid=%b cmd_ready=%b want 0 1", res_valid, cmd_ready);
        end
    endtask

    task automatic test_add();
        send(1'b0, 3'b000, 4'h1, 1'b0, 1'b0);
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL add_early: res_valid=%b want 0", res_valid); end
        checks++;
        if ({alu_op, alu_in_c, alu_in_x, alu_in_y} !== {3'b000, 1'b0, 4'h7, 4'h1}) begin
            errors++;
            $display("FAIL add_drive: op=%b c=%b x=%h y=%h want 000 0 7 1",
                     alu_op, alu_in_c, alu_in_x, alu_in_y);
        end
        step();
        checks++;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL add_latency: res_valid=%b want 1", res_valid); end
        checks++;
        if ({res_s, res_c, res_zero, res_of, acc} !== {4'h8, 1'b0, 1'b0, 1'b1, 4'h8}) begin
            errors++;
            $display("FAIL add_result: s=%h c=%b z=%b of=%b acc=%h want 8 0 0 1 8",
                     res_s, res_c, res_zero, res_of, acc);
        end
        consume();
    endtask

    task automatic test_carry_chain();
        send(1'b0, 3'b000, 4'h8, 1'b0, 1'b0);
        step();
        checks++;
        if ({res_s, res_c, res_zero, res_of} !== {4'h0, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL carry_result: s=%h c=%b z=%b of=%b want 0 1 1 1",
                     res_s, res_c, res_zero, res_of);
        end
        consume();
        send(1'b0, 3'b000, 4'h0, 1'b0, 1'b1);
        checks++;
        if (alu_in_c !== 1'b1) begin errors++; $display("FAIL chain_cin: alu_in_c=%b want 1", alu_in_c); end
        step();
        checks++;
        if ({res_s, res_c, acc} !== {4'h1, 1'b0, 4'h1}) begin
            errors++;
            $display("FAIL chain_result: s=%h c=%b acc=%h want 1 0 1", res_s, res_c, acc);
        end
        consume();
    endtask

    task automatic test_stall();
        send(1'b0, 3'b000, 4'h2, 1'b0, 1'b0);
        step();
        cmd_load = 1'b1; cmd_data = 4'hF; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({res_valid, res_s, cmd_ready, acc} !== {1'b1, 4'h3, 1'b0, 4'h3}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b s=%h ready=%b acc=%h want 1 3 0 3",
                         i, res_valid, res_s, cmd_ready, acc);
            end
            step();
        end
        res_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        step();
        checks++;
        if ({res_valid, acc} !== {1'b0, 4'h3}) begin
            errors++;
            $display("FAIL stall_no_queue: valid=%b acc=%h want 0 3", res_valid, acc);
        end
    endtask

    task automatic test_reset_exec();
        send(1'b1, 3'b000, 4'hF, 1'b0, 1'b0);
        consume();
        send(1'b0, 3'b000, 4'h1, 1'b0, 1'b0);
        step();
        consume();
        send(1'b0, 3'b000, 4'h5, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        checks++;
        if ({res_valid, acc, cmd_ready} !== {1'b0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL rst_exec: valid=%b acc=%h ready=%b want 0 0 0", res_valid, acc, cmd_ready);
        end
        rst = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_result[%0d]: res_valid=%b want 0", i, res_valid);
            end
            step();
        end
        res_ready = 1'b0;
        send(1'b0, 3'b000, 4'h0, 1'b0, 1'b1);
        checks++;
        if (alu_in_c !== 1'b0) begin errors++; $display("FAIL rst_cflag: alu_in_c=%b want 0", alu_in_c); end
        step();
        checks++;
        if ({res_s, res_zero} !== {4'h0, 1'b1}) begin
            errors++;
            $display("FAIL rst_chain_result: s=%h z=%b want 0 1", res_s, res_zero);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        localparam int N = 8;
        logic       ld  [N];
        logic [2:0] opv [N];
        logic [3:0] dv  [N];
        logic       civ [N];
        logic       selv[N];
        logic [6:0] exq [$];
        logic [6:0] r;
        logic [3:0] m_acc;
        logic       m_cf;
        logic       prev_ld;
        int         i, nres, cyc, last;
        ld[0]=1; opv[0]=0; dv[0]=4'h3; civ[0]=0; selv[0]=0;
        ld[1]=0; opv[1]=0; dv[1]=4'h5; civ[1]=0; selv[1]=0;
        ld[2]=0; opv[2]=0; dv[2]=4'h9; civ[2]=0; selv[2]=0;
        ld[3]=0; opv[3]=0; dv[3]=4'h0; civ[3]=0; selv[3]=1;
        ld[4]=0; opv[4]=1; dv[4]=4'h6; civ[4]=0; selv[4]=0;
        ld[5]=1; opv[5]=0; dv[5]=4'h0; civ[5]=0; selv[5]=0;
        ld[6]=0; opv[6]=2; dv[6]=4'hA; civ[6]=0; selv[6]=0;
        ld[7]=0; opv[7]=0; dv[7]=4'hF; civ[7]=1; selv[7]=0;
        m_acc = 4'h0; m_cf = 1'b0; prev_ld = 1'b0;
        i = 0; nres = 0; cyc = 0; last = -1;
        res_ready = 1'b1;
        while ((i < N || nres < N) && cyc < 100) begin
            if (res_valid) begin
                checks++;
                if (nres >= N || {res_s, res_c, res_zero, res_of} !== exq[0]) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got s=%h c=%b z=%b of=%b want %b",
                             nres, res_s, res_c, res_zero, res_of, (exq.size() > 0) ? exq[0] : 7'h0);
                end
                if (exq.size() > 0) void'(exq.pop_front());
                nres++;
            end
            if (i < N) begin
                cmd_load = ld[i]; cmd_op = opv[i]; cmd_data = dv[i];
                cmd_cin = civ[i]; cmd_cin_sel = selv[i]; cmd_valid = 1'b1;
                if (cmd_ready) begin
                    if (ld[i]) begin
                        r = {dv[i], 1'b0, (dv[i] == 4'h0), 1'b0};
                    end else begin
                        r = alu_f(opv[i], selv[i] ? m_cf : civ[i], m_acc, dv[i]);
                        m_cf = r[2];
                    end
                    m_acc = r[6:3];
                    exq.push_back(r);
                    if (last >= 0) begin
                        checks++;
                        if (cyc - last != (prev_ld ? 2 : 3)) begin
                            errors++;
                            $display("FAIL b2b_gap[%0d]: got %0d cycles want %0d",
                                     i, cyc - last, prev_ld ? 2 : 3);
                        end
                    end
                    last = cyc;
                    prev_ld = ld[i];
                    i++;
                end
            end else begin
                cmd_valid = 1'b0;
            end
            step();
            cyc++;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        checks++;
        if (nres != N || i != N) begin
            errors++;
            $display("FAIL b2b_count: results=%0d accepted=%0d want %0d", nres, i, N);
        end
        checks++;
        if (acc !== m_acc) begin errors++; $display("FAIL b2b_acc: got %h want %h", acc, m_acc); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_add();
        test_carry_chain();
        test_stall();
        test_reset_exec();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
